// File: rtl/overlay_msg_ctrl.sv
// Frame-synchronous HDMI overlay sequencer: snapshots vendor state once per frame,
// converts amounts to BCD by double-dabble and commits all display outputs together.
module overlay_msg_ctrl #(
  parameter int unsigned CHANGE_HOLD_FRAMES = 180,
  parameter int unsigned BLINK_FRAMES       = 30,
  parameter int unsigned AMOUNT_MAX         = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [1:0] vend_state,
  input  logic [7:0] total,
  input  logic [7:0] change,
  output logic [1:0] disp_state,
  output logic       show_text,
  output logic [3:0] total_tens,
  output logic [3:0] total_ones,
  output logic [3:0] change_tens,
  output logic [3:0] change_ones,
  output logic       busy
);

  localparam int unsigned HW = $clog2(CHANGE_HOLD_FRAMES + 1);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(CHANGE_HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    AMAX       = 8'(AMOUNT_MAX);

  typedef enum logic [1:0] {
    IDLE_WAIT   = 2'd0,
    CONV_TOTAL  = 2'd1,
    CONV_CHANGE = 2'd2,
    COMMIT      = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    iter_q, iter_d;
  logic [15:0]   sr_q, sr_d;
  logic [1:0]    cap_state_q, cap_state_d;
  logic [7:0]    cap_change_q, cap_change_d;
  logic [7:0]    tot_bcd_q, tot_bcd_d;
  logic [1:0]    disp_q, disp_d;
  logic          show_q, show_d;
  logic [3:0]    tt_q, tt_d, to_q, to_d, ct_q, ct_d, co_q, co_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [15:0]   step;

  function automatic logic [7:0] sat(input logic [7:0] a);
    return (a > AMAX) ? AMAX : a;
  endfunction

  // {tens, ones, binary}: add-3 to BCD nibbles >= 5, then shift left one bit.
  function automatic logic [15:0] dd_step(input logic [15:0] sr);
    logic [15:0] t;
    t = sr;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    sr_d         = sr_q;
    cap_state_d  = cap_state_q;
    cap_change_d = cap_change_q;
    tot_bcd_d    = tot_bcd_q;
    disp_d       = disp_q;
    show_d       = show_q;
    tt_d         = tt_q;
    to_d         = to_q;
    ct_d         = ct_q;
    co_d         = co_q;
    hold_d       = hold_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    step         = dd_step(sr_q);

    // Frame counters advance on every frame_start, busy or not; COMMIT below overrides.
    if (frame_start) begin
      if (hold_q != '0 && disp_q == 2'b10) hold_d = hold_q - HW'(1);
      if (disp_q == 2'b00) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end else begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end
    end

    case (state_q)
      IDLE_WAIT: begin
        if (frame_start) begin
          cap_state_d  = vend_state;
          cap_change_d = sat(change);
          sr_d         = {8'h00, sat(total)};
          iter_d       = '0;
          state_d      = CONV_TOTAL;
        end
      end
      CONV_TOTAL: begin
        iter_d = iter_q + 3'd1;
        sr_d   = step;
        if (iter_q == 3'd7) begin
          tot_bcd_d = step[15:8];
          sr_d      = {8'h00, cap_change_q};
          state_d   = CONV_CHANGE;
        end
      end
      CONV_CHANGE: begin
        iter_d = iter_q + 3'd1;
        sr_d   = step;
        if (iter_q == 3'd7) state_d = COMMIT;
      end
      default: begin
        tt_d    = tot_bcd_q[7:4];
        to_d    = tot_bcd_q[3:0];
        ct_d    = sr_q[15:12];
        co_d    = sr_q[11:8];
        state_d = IDLE_WAIT;
        case (cap_state_q)
          2'b10: begin
            if (disp_q != 2'b10) hold_d = HOLD_LOAD;
            disp_d = 2'b10;
            show_d = 1'b1;
          end
          2'b01: begin
            disp_d = 2'b01;
            hold_d = '0;
            show_d = 1'b1;
          end
          2'b00: begin
            if (hold_q != '0) begin
              disp_d = 2'b10;
              ct_d   = ct_q;
              co_d   = co_q;
              show_d = 1'b1;
            end else begin
              disp_d = 2'b00;
              show_d = phase_q;
            end
          end
          default: show_d = 1'b0;
        endcase
        if (cap_state_q != 2'b11 && disp_d != 2'b00) begin
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE_WAIT;
      iter_q       <= '0;
      sr_q         <= '0;
      cap_state_q  <= '0;
      cap_change_q <= '0;
      tot_bcd_q    <= '0;
      disp_q       <= '0;
      show_q       <= 1'b0;
      tt_q         <= '0;
      to_q         <= '0;
      ct_q         <= '0;
      co_q         <= '0;
      hold_q       <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      sr_q         <= sr_d;
      cap_state_q  <= cap_state_d;
      cap_change_q <= cap_change_d;
      tot_bcd_q    <= tot_bcd_d;
      disp_q       <= disp_d;
      show_q       <= show_d;
      tt_q         <= tt_d;
      to_q         <= to_d;
      ct_q         <= ct_d;
      co_q         <= co_d;
      hold_q       <= hold_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign disp_state  = disp_q;
  assign show_text   = show_q;
  assign total_tens  = tt_q;
  assign total_ones  = to_q;
  assign change_tens = ct_q;
  assign change_ones = co_q;
  assign busy        = (state_q != IDLE_WAIT);

endmodule

// File: tb/tb_overlay_msg_ctrl.sv
// Directed self-checking bench for overlay_msg_ctrl; expected values hand-computed.
module tb_overlay_msg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] vend_state = 2'b00;
  logic [7:0] total = 8'd0;
  logic [7:0] change = 8'd0;
  logic [1:0] disp_state;
  logic       show_text;
  logic [3:0] total_tens, total_ones, change_tens, change_ones;
  logic       busy;

  int checks = 0;
  int passes = 0;

  overlay_msg_ctrl #(
    .CHANGE_HOLD_FRAMES(180),
    .BLINK_FRAMES(30),
    .AMOUNT_MAX(99)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .vend_state(vend_state), .total(total), .change(change),
    .disp_state(disp_state), .show_text(show_text),
    .total_tens(total_tens), .total_ones(total_ones),
    .change_tens(change_tens), .change_ones(change_ones),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {disp_state, show_text, total_tens, total_ones, change_tens, change_ones}
  function automatic logic [18:0] outs();
    return {disp_state, show_text, total_tens, total_ones, change_tens, change_ones};
  endfunction

  // Pulse frame_start so it is sampled at edge E0; returns #1 after E0.
  task automatic pulse(input logic [1:0] vs, input logic [7:0] t, input logic [7:0] c);
    @(negedge clk);
    vend_state = vs; total = t; change = c; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // One full frame: snapshot at E0, returns #1 after the commit edge E17.
  task automatic run_frame(input logic [1:0] vs, input logic [7:0] t, input logic [7:0] c);
    pulse(vs, t, c);
    repeat (17) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({outs(), busy} !== 20'h0) $display("FAIL reset_state: got %h want %h", {outs(), busy}, 20'h0);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    logic bad;
    bad = 1'b0;
    pulse(2'b01, 8'd75, 8'd0);
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1 || disp_state !== 2'b00) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) $display("FAIL busy_window: busy low or outputs moved before E17");
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_end: got %b want 0", busy);
    else passes++;
    checks++;
    if (outs() !== {2'b01, 1'b1, 4'd7, 4'd5, 4'd0, 4'd0})
      $display("FAIL basic_commit: got %h want %h", outs(), {2'b01, 1'b1, 4'd7, 4'd5, 4'd0, 4'd0});
    else passes++;
  endtask

  task automatic test_saturation;
    run_frame(2'b10, 8'd200, 8'd255);
    checks++;
    if (outs() !== {2'b10, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9})
      $display("FAIL saturation: got %h want %h", outs(), {2'b10, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9});
    else passes++;
    run_frame(2'b01, 8'd0, 8'd0);
    checks++;
    if (outs() !== {2'b01, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0})
      $display("FAIL sat_to_collect: got %h want %h", outs(), {2'b01, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0});
    else passes++;
  endtask

  task automatic test_hold;
    int bad;
    bad = 0;
    run_frame(2'b10, 8'd0, 8'd25);
    checks++;
    if (outs() !== {2'b10, 1'b1, 4'd0, 4'd0, 4'd2, 4'd5})
      $display("FAIL hold_entry: got %h want %h", outs(), {2'b10, 1'b1, 4'd0, 4'd0, 4'd2, 4'd5});
    else passes++;
    for (int i = 1; i < 180; i++) begin
      run_frame(2'b00, 8'd0, 8'd0);
      if (outs() !== {2'b10, 1'b1, 4'd0, 4'd0, 4'd2, 4'd5}) begin
        if (bad == 0)
          $display("FAIL hold_frame: frame %0d got %h want %h", i, outs(), {2'b10, 1'b1, 4'd0, 4'd0, 4'd2, 4'd5});
        bad++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL hold_frames: %0d bad frames want 0", bad);
    else passes++;
    run_frame(2'b00, 8'd0, 8'd0);
    checks++;
    if (outs() !== {2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0})
      $display("FAIL hold_expire: got %h want %h", outs(), {2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0});
    else passes++;
  endtask

  task automatic test_preempt;
    run_frame(2'b10, 8'd0, 8'd40);
    run_frame(2'b00, 8'd0, 8'd0);
    checks++;
    if (outs() !== {2'b10, 1'b1, 4'd0, 4'd0, 4'd4, 4'd0})
      $display("FAIL preempt_hold: got %h want %h", outs(), {2'b10, 1'b1, 4'd0, 4'd0, 4'd4, 4'd0});
    else passes++;
    run_frame(2'b01, 8'd5, 8'd0);
    checks++;
    if (outs() !== {2'b01, 1'b1, 4'd0, 4'd5, 4'd0, 4'd0})
      $display("FAIL preempt_collect: got %h want %h", outs(), {2'b01, 1'b1, 4'd0, 4'd5, 4'd0, 4'd0});
    else passes++;
    run_frame(2'b00, 8'd0, 8'd0);
    checks++;
    if (outs() !== {2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0})
      $display("FAIL preempt_cleared: got %h want %h", outs(), {2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0});
    else passes++;
  endtask

  task automatic test_blink;
    int bad;
    logic ph;
    bad = 0;
    run_frame(2'b01, 8'd12, 8'd34);
    for (int i = 0; i < 120; i++) begin
      run_frame(2'b00, 8'd12, 8'd34);
      ph = ((i / 30) % 2) == 1;
      if (outs() !== {2'b00, ph, 4'd1, 4'd2, 4'd3, 4'd4}) begin
        if (bad == 0)
          $display("FAIL blink_frame: frame %0d got %h want %h", i, outs(), {2'b00, ph, 4'd1, 4'd2, 4'd3, 4'd4});
        bad++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL blink_pattern: %0d bad frames want 0", bad);
    else passes++;
  endtask

  task automatic test_invalid;
    run_frame(2'b11, 8'd55, 8'd66);
    checks++;
    if (outs() !== {2'b00, 1'b0, 4'd5, 4'd5, 4'd6, 4'd6})
      $display("FAIL invalid_state: got %h want %h", outs(), {2'b00, 1'b0, 4'd5, 4'd5, 4'd6, 4'd6});
    else passes++;
  endtask

  task automatic test_busy_ignore;
    pulse(2'b01, 8'd42, 8'd0);
    repeat (4) @(posedge clk);
    // frame_start sampled at E5, mid-conversion
    @(negedge clk);
    vend_state = 2'b10; total = 8'd99; change = 8'd99; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if ({outs(), busy} !== {2'b01, 1'b1, 4'd4, 4'd2, 4'd0, 4'd0, 1'b0})
      $display("FAIL busy_ignore: got %h want %h", {outs(), busy}, {2'b01, 1'b1, 4'd4, 4'd2, 4'd0, 4'd0, 1'b0});
    else passes++;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || outs() !== {2'b01, 1'b1, 4'd4, 4'd2, 4'd0, 4'd0})
      $display("FAIL busy_no_resnap: got %h busy %b want %h busy 0", outs(), busy, {2'b01, 1'b1, 4'd4, 4'd2, 4'd0, 4'd0});
    else passes++;
  endtask

  task automatic test_reset_mid;
    pulse(2'b10, 8'd88, 8'd77);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({outs(), busy} !== 20'h0) $display("FAIL reset_async: got %h want %h", {outs(), busy}, 20'h0);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({outs(), busy} !== 20'h0) $display("FAIL reset_no_commit: got %h want %h", {outs(), busy}, 20'h0);
    else passes++;
    run_frame(2'b01, 8'd33, 8'd0);
    checks++;
    if (outs() !== {2'b01, 1'b1, 4'd3, 4'd3, 4'd0, 4'd0})
      $display("FAIL reset_recover: got %h want %h", outs(), {2'b01, 1'b1, 4'd3, 4'd3, 4'd0, 4'd0});
    else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_hold;
    test_preempt;
    test_blink;
    test_invalid;
    test_busy_ignore;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
